// File: rtl/scroll_timer_ctrl_if.sv
// Avalon-MM write-only link between scroll_timer_ctrl and the interval timer slave.
// The timer slave drives tmr_irq back to the controller.
interface scroll_timer_ctrl_if;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic        tmr_irq;

    modport master (
        output tmr_address,
        output tmr_chipselect,
        output tmr_write_n,
        output tmr_writedata,
        input  tmr_irq
    );

    modport slave (
        input  tmr_address,
        input  tmr_chipselect,
        input  tmr_write_n,
        input  tmr_writedata,
        output tmr_irq
    );
endinterface

// File: rtl/scroll_timer_ctrl.sv
// Programs the interval timer, services its timeout IRQ and advances a wrapping
// horizontal scroll position once per timeout, with no CPU involvement per step.
module scroll_timer_ctrl #(
    parameter logic [31:0] DEFAULT_PERIOD = 32'h0001869F,
    parameter int          SCROLL_MAX     = 640,
    parameter int          XW             = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_start,
    input  logic          cmd_stop,
    input  logic          cmd_set_period,
    input  logic [31:0]   cmd_period,
    input  logic          scroll_dir,
    output logic          cmd_busy,
    output logic          running,
    output logic [XW-1:0] scroll_x,
    output logic          scroll_step,
    output logic          scroll_wrap,
    scroll_timer_ctrl_if.master tmr
);

    typedef enum logic [2:0] {
        IDLE,
        WR_PL,
        WR_PH,
        WR_CTRL,
        RUN,
        ACK,
        WR_STOP,
        WR_CLR
    } state_t;

    localparam logic [XW-1:0] X_LAST = XW'(SCROLL_MAX - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);

    state_t        state_q, state_d;
    logic [31:0]   per_q, per_d;
    logic          reprog_q, reprog_d;
    logic [XW-1:0] scroll_x_q, scroll_x_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            per_q      <= DEFAULT_PERIOD;
            reprog_q   <= 1'b0;
            scroll_x_q <= '0;
        end else begin
            state_q    <= state_d;
            per_q      <= per_d;
            reprog_q   <= reprog_d;
            scroll_x_q <= scroll_x_d;
        end
    end

    // Bus strobes and step pulses are pure decodes of the current state.
    always_comb begin
        state_d            = state_q;
        per_d              = per_q;
        reprog_d           = reprog_q;
        scroll_x_d         = scroll_x_q;
        scroll_step        = 1'b0;
        scroll_wrap        = 1'b0;
        tmr.tmr_address    = 3'd0;
        tmr.tmr_chipselect = 1'b0;
        tmr.tmr_write_n    = 1'b1;
        tmr.tmr_writedata  = 16'h0000;

        case (state_q)
            IDLE: begin
                if (cmd_set_period) begin
                    per_d = cmd_period;
                end
                if (cmd_start) begin
                    reprog_d = 1'b0;
                    state_d  = WR_PL;
                end
            end
            WR_PL: begin
                tmr.tmr_chipselect = 1'b1;
                tmr.tmr_write_n    = 1'b0;
                tmr.tmr_address    = 3'd2;
                tmr.tmr_writedata  = per_q[15:0];
                state_d            = WR_PH;
            end
            WR_PH: begin
                tmr.tmr_chipselect = 1'b1;
                tmr.tmr_write_n    = 1'b0;
                tmr.tmr_address    = 3'd3;
                tmr.tmr_writedata  = per_q[31:16];
                state_d            = WR_CTRL;
            end
            // START must land right after the period writes to undo their force-reload stop.
            WR_CTRL: begin
                tmr.tmr_chipselect = 1'b1;
                tmr.tmr_write_n    = 1'b0;
                tmr.tmr_address    = 3'd1;
                tmr.tmr_writedata  = 16'h0007;
                state_d            = RUN;
            end
            RUN: begin
                if (cmd_stop) begin
                    state_d = WR_STOP;
                end else if (cmd_set_period) begin
                    per_d    = cmd_period;
                    reprog_d = 1'b1;
                    state_d  = WR_PL;
                end else if (tmr.tmr_irq) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                tmr.tmr_chipselect = 1'b1;
                tmr.tmr_write_n    = 1'b0;
                scroll_step        = 1'b1;
                if (scroll_dir) begin
                    if (scroll_x_q == '0) begin
                        scroll_x_d  = X_LAST;
                        scroll_wrap = 1'b1;
                    end else begin
                        scroll_x_d = scroll_x_q - X_ONE;
                    end
                end else begin
                    if (scroll_x_q == X_LAST) begin
                        scroll_x_d  = '0;
                        scroll_wrap = 1'b1;
                    end else begin
                        scroll_x_d = scroll_x_q + X_ONE;
                    end
                end
                state_d = RUN;
            end
            WR_STOP: begin
                tmr.tmr_chipselect = 1'b1;
                tmr.tmr_write_n    = 1'b0;
                tmr.tmr_address    = 3'd1;
                tmr.tmr_writedata  = 16'h0008;
                state_d            = WR_CLR;
            end
            WR_CLR: begin
                tmr.tmr_chipselect = 1'b1;
                tmr.tmr_write_n    = 1'b0;
                state_d            = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_busy = (state_q != IDLE) && (state_q != RUN);
    assign running  = (state_q == RUN) ||
                      (reprog_q && ((state_q == WR_PL) || (state_q == WR_PH) || (state_q == WR_CTRL)));
    assign scroll_x = scroll_x_q;

endmodule

// File: doc/scroll_timer_ctrl.md
# scroll_timer_ctrl

Avalon-MM master that owns the horizontal-scroll interval timer (16-bit register map: status@0, control@1, period_l@2, period_h@3). Programs the period, starts and stops the timer in continuous interrupt mode, services its IRQ by clearing status, and advances a wrapping scroll X position once per timeout. Sits between the software-visible scroll command register and the timer slave, so no CPU interrupt handling is needed per scroll step.

## Interface
- DEFAULT_PERIOD, 32'h0001869F, period load value (timeout every N+1 clk) used until `cmd_period` is latched.
- SCROLL_MAX, 640, number of scroll positions; `scroll_x` range 0..SCROLL_MAX-1.
- XW, 10, width of `scroll_x`; must satisfy 2^XW >= SCROLL_MAX.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_start  in  1  one-cycle pulse: program period and start timer.
- cmd_stop  in  1  one-cycle pulse: stop timer, clear pending timeout.
- cmd_set_period  in  1  one-cycle pulse: latch `cmd_period`; reprogram timer if running.
- cmd_period  in  32  new period load value, sampled with `cmd_set_period`.
- scroll_dir  in  1  0 = increment `scroll_x`, 1 = decrement; sampled in ACK.
- cmd_busy  out  1  high in every state except IDLE and RUN.
- running  out  1  high in RUN and in reprogram states entered from RUN.
- scroll_x  out  XW  current scroll position.
- scroll_step  out  1  one-cycle pulse per serviced timeout.
- scroll_wrap  out  1  one-cycle pulse coincident with `scroll_step` when `scroll_x` wraps.
- tmr_address  out  3  timer slave address.
- tmr_chipselect  out  1  timer slave chipselect.
- tmr_write_n  out  1  timer slave write strobe, active low.
- tmr_writedata  out  16  timer slave write data.
- tmr_irq  in  1  timer interrupt (timeout_occurred AND ITO).

## Operation
- Period register `per` (32b) resets to DEFAULT_PERIOD; loaded from `cmd_period` on `cmd_set_period` when not busy.
- Bus outputs are Moore decodes of the state register. Each write state occupies exactly one cycle: chipselect=1, write_n=0. The timer slave has no waitrequest. Outside write states: chipselect=0, write_n=1, address=0, writedata=0.
- States and transitions:
  - IDLE: `cmd_start` -> WR_PL. `cmd_set_period` latches only, no bus write.
  - WR_PL: addr 2, data `per[15:0]` -> WR_PH.
  - WR_PH: addr 3, data `per[31:16]` -> WR_CTRL.
  - WR_CTRL: addr 1, data 16'h0007 (ITO|CONT|START) -> RUN. It must immediately follow WR_PH: the timer's START strobe overrides the stop caused by its force_reload.
  - RUN: priority is `cmd_stop` -> WR_STOP, then `cmd_set_period` (latch) -> WR_PL, then `tmr_irq` -> ACK. `cmd_start` is ignored.
  - ACK: addr 0, data 0 (clear timeout). Update `scroll_x`, pulse `scroll_step` -> RUN.
  - WR_STOP: addr 1, data 16'h0008 (STOP, ITO=0) -> WR_CLR.
  - WR_CLR: addr 0, data 0 -> IDLE.
- `scroll_x` update in ACK:
  - dir=0: SCROLL_MAX-1 -> 0 with `scroll_wrap`, else +1.
  - dir=1: 0 -> SCROLL_MAX-1 with `scroll_wrap`, else -1.
- Commands arriving while `cmd_busy`=1 are dropped. A `tmr_irq` pending during reprogramming stays asserted in the timer and is serviced on return to RUN.
- `scroll_x` holds its value across stop/start. Only reset clears it.

## Timing
- Reset values: state IDLE, `per`=DEFAULT_PERIOD, scroll_x=0, scroll_step=0, scroll_wrap=0, cmd_busy=0, running=0, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0.
- Reset asserted mid-sequence aborts immediately. No bus cycle is issued after reset asserts.
- Start latency: `cmd_start` at edge n gives writes in cycles n+1, n+2, n+3 and RUN from cycle n+4.
- IRQ service: `tmr_irq` seen in RUN at cycle n gives ACK (status write, `scroll_step`) at cycle n+1 and RUN at n+2. The timer IRQ is already low at n+2, so there is no double count.
- Stop latency: 2 write cycles, then IDLE.
- Reprogram from RUN: 3 write cycles, then RUN. The timer counter reloads with the new period.
- Maximum serviced step rate: one per 2 cycles. A period under 2 clocks loses timeouts; this is documented, not guarded.

## Test plan
- Reset, then `cmd_start`: bus sees (2,16'h869F), (3,16'h0001), (1,16'h0007) on consecutive cycles. `running`=1 from cycle 4. `cmd_busy` high for exactly 3 cycles.
- With period 9 set via `cmd_set_period` before start, and dir=0: `scroll_step` every 10 clocks. Each pulse is preceded by a status write (0,0), and `scroll_x` goes 0,1,2,...
- Wrap: with SCROLL_MAX=4, dir=0 gives x sequence 1,2,3,0 with `scroll_wrap` on the 0 step. With dir=1 from 0, x goes to 3 with `scroll_wrap`.
- `cmd_stop` and `tmr_irq` in the same RUN cycle: stop wins, giving writes (1,16'h0008), (0,0), then IDLE. No `scroll_step`; `scroll_x` unchanged.
- `cmd_set_period`(32'h0000_0013) while running: writes (2,16'h0013), (3,0), (1,7). Steps resume every 20 clocks. A `cmd_start` issued while busy has no effect.
- Assert reset during WR_PH: all outputs return to reset values asynchronously, and no further bus writes occur until the next `cmd_start`.
